// File: rtl/demod_sequencer_pkg.sv
// Shared types for the demodulation back-end sequencer: classifier codes,
// sequencer state encoding and the registered output bundle.
package demod_pkg;

   typedef logic [2:0] sig_t;

   localparam sig_t SIG_CW  = 3'b000;
   localparam sig_t SIG_AM  = 3'b001;
   localparam sig_t SIG_FM  = 3'b010;
   localparam sig_t SIG_ASK = 3'b101;
   localparam sig_t SIG_FSK = 3'b110;
   localparam sig_t SIG_PSK = 3'b111;
   localparam sig_t SIG_NA  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MEAS = 3'd1,
      ST_CAL  = 3'd2,
      ST_OUT  = 3'd3,
      ST_RUN  = 3'd4
   } state_e;

   typedef struct packed {
      logic meas_trigger;
      logic cal_trigger;
      logic out_trigger;
      sig_t type_out;
      logic busy;
      logic done;
      logic timeout_err;
   } seq_out_t;

   localparam seq_out_t SEQ_OUT_RST = seq_out_t'({3'b000, SIG_NA, 3'b000});

endpackage

// File: rtl/demod_sequencer_if.sv
// Handshake bundle between the sequencer (master: drives triggers/status)
// and the back end that feeds it start/change/classifier results (slave).
interface demod_sequencer_if import demod_pkg::*; ();

   logic start;
   logic change_det;
   logic type_valid;
   sig_t signal_type;
   logic meas_trigger;
   logic cal_trigger;
   logic out_trigger;
   sig_t type_out;
   logic busy;
   logic done;
   logic timeout_err;

   modport master (
      input  start, change_det, type_valid, signal_type,
      output meas_trigger, cal_trigger, out_trigger, type_out, busy, done, timeout_err
   );

   modport slave (
      output start, change_det, type_valid, signal_type,
      input  meas_trigger, cal_trigger, out_trigger, type_out, busy, done, timeout_err
   );

endinterface

// File: rtl/demod_sequencer_timer.sv
// Loadable down-counter that sticks at zero; tc flags the zero count.
module seq_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && count != '0)
         count <= count - 1'b1;
   end

   assign tc = (count == '0);

endmodule

// File: rtl/demod_sequencer.sv
// Measure / calibrate / output sequencer: emits one-hot trigger pulses and
// presents a stable classifier result to the DAC selector.
module demod_sequencer
   import demod_pkg::*;
#(
   parameter int MEAS_CYC     = 1000,
   parameter int MEAS_TIMEOUT = 4000,
   parameter int CAL_CYC      = 64,
   parameter int REFRESH_CYC  = 0,
   parameter int AUTO_START   = 1,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   demod_sequencer_if.master bus
);

   // The window timer counts down from MEAS_TIMEOUT-1, so elapsed cycles
   // reach MEAS_CYC-1 once the remaining count drops to WIN_MIN.
   localparam logic [CNT_W-1:0] WIN_MEAS = CNT_W'(MEAS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WIN_CAL  = CNT_W'(CAL_CYC - 1);
   localparam logic [CNT_W-1:0] WIN_MIN  = CNT_W'(MEAS_TIMEOUT - MEAS_CYC);
   localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'((REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0);

   state_e           state, state_nxt;
   seq_out_t         q, q_nxt;
   sig_t             cap_type, cap_nxt;
   logic             seen_valid, seen_nxt;
   logic             restart, meas_entry, valid_now;
   logic             win_load, win_tc, ref_load, ref_tc;
   logic [CNT_W-1:0] win_val, win_cnt, ref_cnt_unused;

   // A restart on the meas_trigger cycle itself is dropped.
   assign restart    = (bus.start || bus.change_det) && state != ST_IDLE &&
                       !(state == ST_MEAS && q.meas_trigger);
   assign valid_now  = seen_valid || bus.type_valid;
   assign meas_entry = state_nxt == ST_MEAS && (state != ST_MEAS || restart);

   assign win_load = meas_entry || (state == ST_MEAS && state_nxt == ST_CAL);
   assign win_val  = meas_entry ? WIN_MEAS : WIN_CAL;
   assign ref_load = state_nxt == ST_RUN && state != ST_RUN;

   seq_timer #(.CNT_W(CNT_W)) u_win (
      .clk      (clk),
      .rst      (rst),
      .load     (win_load),
      .en       (state == ST_MEAS || state == ST_CAL),
      .load_val (win_val),
      .count    (win_cnt),
      .tc       (win_tc)
   );

   seq_timer #(.CNT_W(CNT_W)) u_ref (
      .clk      (clk),
      .rst      (rst),
      .load     (ref_load),
      .en       (state == ST_RUN),
      .load_val (REF_LOAD),
      .count    (ref_cnt_unused),
      .tc       (ref_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         q          <= SEQ_OUT_RST;
         cap_type   <= SIG_NA;
         seen_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         q          <= q_nxt;
         cap_type   <= cap_nxt;
         seen_valid <= seen_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.start || AUTO_START != 0) state_nxt = ST_MEAS;
         ST_MEAS: begin
            if (restart)                          state_nxt = ST_MEAS;
            else if (win_tc && !valid_now)        state_nxt = ST_OUT;
            else if (win_cnt <= WIN_MIN && valid_now) state_nxt = ST_CAL;
         end
         ST_CAL:  begin
            if (restart)     state_nxt = ST_MEAS;
            else if (win_tc) state_nxt = ST_OUT;
         end
         ST_OUT:  state_nxt = restart ? ST_MEAS : ST_RUN;
         ST_RUN:  if (restart || (REFRESH_CYC > 0 && ref_tc)) state_nxt = ST_MEAS;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      q_nxt    = q;
      cap_nxt  = cap_type;
      seen_nxt = seen_valid;

      if (meas_entry) begin
         cap_nxt  = SIG_NA;
         seen_nxt = 1'b0;
      end else if (state == ST_MEAS) begin
         if (bus.type_valid) begin
            cap_nxt  = bus.signal_type;
            seen_nxt = 1'b1;
         end
         if (state_nxt == ST_OUT) cap_nxt = SIG_NA;
      end

      q_nxt.meas_trigger = meas_entry;
      q_nxt.cal_trigger  = state == ST_MEAS && state_nxt == ST_CAL;
      q_nxt.out_trigger  = state_nxt == ST_OUT;
      q_nxt.busy         = state_nxt == ST_MEAS || state_nxt == ST_CAL || state_nxt == ST_OUT;
      q_nxt.done         = state_nxt == ST_RUN;

      if (meas_entry)
         q_nxt.timeout_err = 1'b0;
      else if (state == ST_MEAS && state_nxt == ST_OUT)
         q_nxt.timeout_err = 1'b1;

      // type_out moves on entry to the last CAL cycle, one cycle ahead of out_trigger.
      if (state == ST_MEAS && state_nxt == ST_OUT)
         q_nxt.type_out = SIG_NA;
      else if ((state == ST_MEAS && state_nxt == ST_CAL && CAL_CYC == 1) ||
               (state == ST_CAL && state_nxt == ST_CAL && win_cnt == CNT_W'(1)))
         q_nxt.type_out = cap_nxt;
   end

   assign bus.meas_trigger = q.meas_trigger;
   assign bus.cal_trigger  = q.cal_trigger;
   assign bus.out_trigger  = q.out_trigger;
   assign bus.type_out     = q.type_out;
   assign bus.busy         = q.busy;
   assign bus.done         = q.done;
   assign bus.timeout_err  = q.timeout_err;

endmodule

// File: tb/tb_demod_sequencer.sv
// Bench: two sequencer configurations share one stimulus stream and are
// compared every cycle against a phase/elapsed-cycle reference model.
module tb_demod_sequencer;
   import demod_pkg::*;

   localparam int MC = 8, MTO = 20, CC = 4, RC_B = 10;
   localparam logic [8:0] RST_VEC = 9'b000_100_000;
   localparam int M_IDLE = 0, M_MEAS = 1, M_CAL = 2, M_OUT = 3, M_RUN = 4;

   logic clk = 1'b0, rst = 1'b1;
   logic start = 1'b0, change_det = 1'b0, type_valid = 1'b0;
   logic [2:0] signal_type = 3'b000;
   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [8:0] hist_a [0:255];
   logic [8:0] hist_b [0:255];

   always #5 clk = ~clk;

   demod_sequencer_if if_a ();
   demod_sequencer_if if_b ();

   assign if_a.start = start;       assign if_b.start = start;
   assign if_a.change_det = change_det; assign if_b.change_det = change_det;
   assign if_a.type_valid = type_valid; assign if_b.type_valid = type_valid;
   assign if_a.signal_type = signal_type; assign if_b.signal_type = signal_type;

   demod_sequencer #(.MEAS_CYC(MC), .MEAS_TIMEOUT(MTO), .CAL_CYC(CC),
                     .REFRESH_CYC(0), .AUTO_START(0), .CNT_W(16))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   demod_sequencer #(.MEAS_CYC(MC), .MEAS_TIMEOUT(MTO), .CAL_CYC(CC),
                     .REFRESH_CYC(RC_B), .AUTO_START(1), .CNT_W(16))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));

   logic [8:0] dvec_a, dvec_b;
   assign dvec_a = {if_a.meas_trigger, if_a.cal_trigger, if_a.out_trigger, if_a.type_out,
                    if_a.busy, if_a.done, if_a.timeout_err};
   assign dvec_b = {if_b.meas_trigger, if_b.cal_trigger, if_b.out_trigger, if_b.type_out,
                    if_b.busy, if_b.done, if_b.timeout_err};

   // Model: current phase plus cycles elapsed in it (0 on entry).
   typedef struct {
      int ph; int n; bit seen; logic [2:0] cap; logic [2:0] tout; bit terr; bit mt, ct, ot;
   } mdl_t;
   mdl_t ma, mb;

   function automatic mdl_t mreset();
      mdl_t r;
      r.ph = M_IDLE; r.n = 0; r.seen = 0; r.cap = SIG_NA; r.tout = SIG_NA;
      r.terr = 0; r.mt = 0; r.ct = 0; r.ot = 0;
      return r;
   endfunction

   function automatic mdl_t mstep(mdl_t m, int mc, int mto, int cc, int rc, bit as,
                                  bit rs, bit st, bit chg, bit tv, logic [2:0] sig);
      mdl_t r = m;
      int nph = m.ph;
      bit enter = 0;
      bit req = st || chg;
      if (rs) return mreset();
      r.mt = 0; r.ct = 0; r.ot = 0;
      case (m.ph)
         M_IDLE: enter = st || as;
         M_MEAS: if (req && !m.mt) enter = 1;
                 else begin
                    if (tv) begin r.seen = 1; r.cap = sig; end
                    if (m.n >= mto - 1 && !r.seen) begin
                       nph = M_OUT; r.terr = 1; r.cap = SIG_NA; r.tout = SIG_NA;
                    end else if (m.n >= mc - 1 && r.seen) nph = M_CAL;
                 end
         M_CAL:  if (req) enter = 1; else if (m.n == cc - 1) nph = M_OUT;
         M_OUT:  if (req) enter = 1; else nph = M_RUN;
         default: if (req || (rc > 0 && m.n == rc - 1)) enter = 1;
      endcase
      if (enter) begin
         nph = M_MEAS; r.seen = 0; r.cap = SIG_NA; r.terr = 0; r.mt = 1;
      end
      r.n  = (nph != m.ph || enter) ? 0 : m.n + 1;
      r.ph = nph;
      if (nph == M_CAL && r.n == 0) r.ct = 1;
      if (nph == M_OUT) r.ot = 1;
      if (nph == M_CAL && r.n == cc - 1) r.tout = r.cap;
      return r;
   endfunction

   function automatic logic [8:0] mvec(mdl_t m);
      return {m.mt, m.ct, m.ot, m.tout,
              (m.ph == M_MEAS || m.ph == M_CAL || m.ph == M_OUT), m.ph == M_RUN, m.terr};
   endfunction

   task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   initial begin
      ma = mreset();
      mb = mreset();
   end

   always @(posedge clk) begin
      ma <= mstep(ma, MC, MTO, CC, 0, 1'b0, rst, start, change_det, type_valid, signal_type);
      mb <= mstep(mb, MC, MTO, CC, RC_B, 1'b1, rst, start, change_det, type_valid, signal_type);
   end

   always @(negedge clk) begin
      chk("outputs_a", dvec_a, mvec(ma));
      chk("outputs_b", dvec_b, mvec(mb));
      chk("onehot_a", 9'($countones(dvec_a[8:6]) > 1), 9'd0);
      chk("onehot_b", 9'($countones(dvec_b[8:6]) > 1), 9'd0);
      if (cyc >= 0 && cyc < 256) begin
         hist_a[cyc] = mvec(ma);
         hist_b[cyc] = mvec(mb);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; change_det = 1'b0; type_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic pulse_start(int c);
      run_to(c); start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_change(int c);
      run_to(c); change_det = 1'b1; tick(); change_det = 1'b0;
   endtask

   task automatic pulse_valid(int c, logic [2:0] s);
      run_to(c); type_valid = 1'b1; signal_type = s; tick(); type_valid = 1'b0;
   endtask

   int cnt;

   initial begin
      // Nominal window with one valid result.
      do_reset();
      pulse_start(2);
      pulse_valid(5, SIG_FM);
      run_to(20);
      chk("s1_mt_at3",     9'(hist_a[3][8]), 9'd1);
      chk("s1_no_ct_at10", 9'(hist_a[10][7]), 9'd0);
      chk("s1_ct_at11",    9'(hist_a[11][7]), 9'd1);
      chk("s1_tout_at13",  9'(hist_a[13][5:3]), 9'(SIG_NA));
      chk("s1_tout_at14",  9'(hist_a[14][5:3]), 9'(SIG_FM));
      chk("s1_ot_at15",    9'(hist_a[15][6]), 9'd1);
      chk("s1_done_at16",  9'(hist_a[16][1]), 9'd1);
      chk("s1_b_auto_mt1", 9'(hist_b[1][8]), 9'd1);

      // Latest valid wins.
      do_reset();
      pulse_start(2);
      pulse_valid(4, SIG_AM);
      pulse_valid(7, SIG_PSK);
      run_to(20);
      chk("s3_ot_at15",   9'(hist_a[15][6]), 9'd1);
      chk("s3_tout_at15", 9'(hist_a[15][5:3]), 9'(SIG_PSK));

      // Timeout, then refresh on B, then restart during CAL.
      do_reset();
      pulse_start(2);
      run_to(45);
      chk("s2_ot_at23",   9'(hist_a[23][6]), 9'd1);
      chk("s2_tout_at23", 9'(hist_a[23][5:3]), 9'(SIG_NA));
      chk("s2_terr_at23", 9'(hist_a[23][0]), 9'd1);
      chk("s2_done_at24", 9'(hist_a[24][1]), 9'd1);
      cnt = 0;
      for (int i = 0; i < 45; i++) cnt += int'(hist_a[i][7]);
      chk("s2_no_ct", 9'(cnt), 9'd0);
      chk("s5_b_done33", 9'(hist_b[33][1]), 9'd1);
      chk("s5_b_refresh34", 9'(hist_b[34][8]), 9'd1);
      pulse_start(45);
      pulse_valid(48, SIG_FM);
      pulse_change(55);
      run_to(70);
      chk("s4_terr_at45", 9'(hist_a[45][0]), 9'd1);
      chk("s4_mt_at46",   9'(hist_a[46][8]), 9'd1);
      chk("s4_terr_at46", 9'(hist_a[46][0]), 9'd0);
      chk("s4_ct_at54",   9'(hist_a[54][7]), 9'd1);
      chk("s4_mt_at56",   9'(hist_a[56][8]), 9'd1);
      cnt = 0;
      for (int i = 46; i < 70; i++) cnt += int'(hist_a[i][6]);
      chk("s4_no_ot", 9'(cnt), 9'd0);

      // Reset mid-MEAS, then mid-CAL after type_out has moved.
      do_reset();
      pulse_start(2);
      run_to(6);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("s6_meas_rst_a", dvec_a, RST_VEC);
      chk("s6_meas_rst_b", dvec_b, RST_VEC);
      pulse_start(10);
      pulse_valid(13, SIG_FM);
      run_to(22);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("s6_cal_rst_a", dvec_a, RST_VEC);
      chk("s6_cal_rst_b", dvec_b, RST_VEC);
      run_to(26);
      chk("s6_ct_at19",   9'(hist_a[19][7]), 9'd1);
      chk("s6_tout_at22", 9'(hist_a[22][5:3]), 9'(SIG_FM));
      chk("s6_hist_23",   hist_a[23], RST_VEC);
      chk("s6_no_ot_24",  9'(hist_a[24][6]), 9'd0);

      // Randomised traffic, alternating dense and sparse classifier results.
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         rst         = ($urandom_range(0, 699) == 0);
         start       = ($urandom_range(0, 59) == 0);
         change_det  = ($urandom_range(0, 79) == 0);
         type_valid  = (((i / 500) % 2) == 0) ? ($urandom_range(0, 5) == 0)
                                              : ($urandom_range(0, 39) == 0);
         signal_type = 3'($urandom_range(0, 7));
         tick();
      end
      rst = 1'b0; start = 1'b0; change_det = 1'b0; type_valid = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
